if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline, directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues one request at a time to an instruction memory with a valid/ready handshake and variable latency.
- Buffers the returned word, then presents PC+4 and the instruction to IF/ID.
- Honours hazard freeze and EXE-stage branch redirect, including discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard-unit stall; the presented instruction is not consumed this cycle.
- branch_taken  in  1  redirect from EXE; overrides freeze.
- branch_addr  in  32  redirect target.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  request byte address.
- imem_ready  in  1  memory accepts the request this cycle (handshake = imem_req & imem_ready).
- imem_rvalid  in  1  response valid; exactly one response per accepted request.
- imem_rdata  in  32  response instruction word.
- PC  out  32  address of presented instruction + PC_STEP; 0 when fetch_valid=0.
- instruction  out  32  presented instruction; 32'h0 (bubble) when fetch_valid=0.
- fetch_valid  out  1  presented instruction is real.

Behaviour:
- State registers: fetch_pc (32), req_pc (32), inst_buf (32), and state in {S_REQ, S_WAIT, S_HOLD, S_DISCARD}.
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, state=S_REQ, inst_buf=0. While rst=1, imem_req=0, fetch_valid=0, PC=0, instruction=0.
- S_REQ:
  - imem_req=~branch_taken; imem_addr=fetch_pc.
  - On handshake: req_pc<=fetch_pc, go to S_WAIT.
  - Otherwise stay.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid: inst_buf<=imem_rdata, go to S_HOLD.
- S_HOLD:
  - fetch_valid=1, instruction=inst_buf, PC=req_pc+PC_STEP.
  - imem_req=~freeze & ~branch_taken; imem_addr=req_pc+PC_STEP.
  - If ~freeze: fetch_pc<=req_pc+PC_STEP. Then, on handshake, req_pc<=req_pc+PC_STEP and go to S_WAIT; without handshake, go to S_REQ.
  - If freeze: hold all state.
- Throughput: zero-wait memory (ready=1, rvalid the following cycle) delivers one instruction every 2 cycles. First valid instruction appears 2 cycles after reset release.
- Branch (branch_taken=1) has priority over freeze and everything else:
  - fetch_pc<=branch_addr and imem_req is forced to 0 that cycle.
  - In S_REQ: stay in S_REQ.
  - In S_HOLD: inst_buf is dropped; go to S_REQ (the current instruction is still visible that cycle; downstream flush handles it).
  - In S_WAIT with imem_rvalid=0: go to S_DISCARD.
  - In S_WAIT with imem_rvalid=1: drop the data; go to S_REQ.
  - In S_DISCARD: update fetch_pc only.
- S_DISCARD:
  - imem_req=0.
  - On imem_rvalid: drop the data; go to S_REQ.
- imem_rvalid in S_REQ or S_HOLD is a protocol violation; it is ignored.
- A back-to-back branch in the cycle after a redirect simply retargets fetch_pc.
- Address arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.
- Reset mid-transaction returns the block to S_REQ. Any in-flight response arriving later is ignored, because the memory is reset on the same rst.

Decomposition:
- Shared package / defines.v entries: state encodings S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2, S_DISCARD=2'd3; NOP_INSTR=32'h0; PC_STEP default.
- One sub-module: if_pc_reg. It holds fetch_pc with synchronous reset to RESET_PC, and takes load (branch_addr) and advance (req_pc+PC_STEP) inputs, with load priority.

Test Plan:
- Reset, then zero-wait memory returning word = addr ^ 32'hE000_0000 -> valid instructions at PC=4,8,12 with matching data; fetch_valid toggles 1,0,1,0.
- Memory ready held 0 for 3 cycles at addr 0 -> imem_req stays 1, imem_addr stays 0, fetch_valid=0; the request is accepted on cycle 4.
- freeze=1 for 4 cycles while in S_HOLD with instruction=32'hE3A01005, PC=8 -> outputs stable, imem_req=0; the next request is to addr 8 after release.
- branch_taken with branch_addr=32'h40 while in S_WAIT (rvalid 2 cycles later) -> stale data dropped, never valid; next request addr=32'h40; next valid output has PC=32'h44.
- branch_taken and freeze together in S_HOLD with branch_addr=32'h100 -> buffer dropped, next imem_addr=32'h100.
- rst asserted in S_WAIT -> next cycle imem_req=1 at RESET_PC, fetch_valid=0, instruction=0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    StReq     = 2'd0,
    StWait    = 2'd1,
    StHold    = 2'd2,
    StDiscard = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/if_pc_reg.sv
// Architectural fetch PC register: redirect load wins over sequential advance.
module if_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  logic        advance_i,
  input  logic [31:0] advance_addr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_addr_i;
    end else if (advance_i) begin
      pc_q <= advance_addr_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: one outstanding imem request, buffers the returned word for IF/ID,
// handles freeze and branch redirect, and discards stale in-flight responses.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        fetch_valid
);

  localparam logic [31:0] Step = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  inst_buf_q, inst_buf_d;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic         handshake;
  logic         pc_advance;

  assign next_pc    = req_pc_q + Step;
  assign handshake  = imem_req & imem_ready;
  assign pc_advance = (state_q == StHold) & ~freeze;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .load_i         (branch_taken),
    .load_addr_i    (branch_addr),
    .advance_i      (pc_advance),
    .advance_addr_i (next_pc),
    .pc_o           (fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      req_pc_q   <= RESET_PC;
      inst_buf_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    inst_buf_d = inst_buf_q;
    unique case (state_q)
      StReq: begin
        if (!branch_taken && handshake) begin
          req_pc_d = fetch_pc;
          state_d  = StWait;
        end
      end
      StWait: begin
        // A redirect while waiting makes the pending response stale.
        if (branch_taken) begin
          state_d = imem_rvalid ? StReq : StDiscard;
        end else if (imem_rvalid) begin
          inst_buf_d = imem_rdata;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (branch_taken) begin
          inst_buf_d = NOP_INSTR;
          state_d    = StReq;
        end else if (!freeze) begin
          if (handshake) begin
            req_pc_d = next_pc;
            state_d  = StWait;
          end else begin
            state_d = StReq;
          end
        end
      end
      StDiscard: begin
        if (imem_rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = fetch_pc;
    fetch_valid = 1'b0;
    PC          = 32'h0;
    instruction = NOP_INSTR;
    if (!rst) begin
      unique case (state_q)
        StReq: begin
          imem_req = ~branch_taken;
        end
        StHold: begin
          imem_req    = ~freeze & ~branch_taken;
          imem_addr   = next_pc;
          fetch_valid = 1'b1;
          PC          = next_pc;
          instruction = inst_buf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed phases queue hand-computed
// (PC, instruction) pairs; a negedge monitor pops them as instructions are consumed.
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        fetch_valid;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  // Memory model: single outstanding request, latency in cycles after acceptance.
  int unsigned lat = 1;
  bit          special_en = 1'b0;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PC           (PC),
    .instruction  (instruction),
    .fetch_valid  (fetch_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (special_en && a == 32'h4) return 32'hE3A0_1005;
    return a ^ 32'hE000_0000;
  endfunction

  assign imem_rvalid = pend && (pend_cnt == 0);
  assign imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      pend_cnt <= 0;
      pend_addr <= 32'h0;
    end else begin
      if (imem_rvalid) pend <= 1'b0;
      if (imem_req && imem_ready) begin
        pend      <= 1'b1;
        pend_addr <= imem_addr;
        pend_cnt  <= lat - 1;
      end else if (pend && pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Monitor: an instruction is consumed when valid and neither frozen nor flushed.
  always @(negedge clk) begin
    if (!rst && fetch_valid && !freeze && !branch_taken) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: got PC=%h instr=%h, required no output",
                 PC, instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pc", PC, e.pc);
        chk("mon_instr", instruction, e.ins);
      end
    end
  end

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  // Leaves the bench at the start of cycle c0 (first cycle after reset release).
  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    imem_ready = 1'b1;
    adv();
    settle();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    adv();
    rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) adv();
  endtask

  initial begin
    // Phase 1: zero-wait memory, sequential stream.
    special_en = 1'b0;
    lat = 1;
    do_reset();
    push(32'd4, 32'hE000_0000);
    push(32'd8, 32'hE000_0004);
    push(32'd12, 32'hE000_0008);
    settle(); chk("p1_c0_valid", {31'b0, fetch_valid}, 32'd0);
    chk("p1_c0_addr", imem_addr, 32'h0);
    adv(); adv();
    settle(); chk("p1_c2_valid", {31'b0, fetch_valid}, 32'd1);
    adv(); settle(); chk("p1_c3_valid", {31'b0, fetch_valid}, 32'd0);
    adv(); settle(); chk("p1_c4_valid", {31'b0, fetch_valid}, 32'd1);
    adv(); settle(); chk("p1_c5_valid", {31'b0, fetch_valid}, 32'd0);
    adv(); settle(); chk("p1_c6_valid", {31'b0, fetch_valid}, 32'd1);
    adv();

    // Phase 2: memory not ready for 3 cycles.
    do_reset();
    imem_ready = 1'b0;
    push(32'd4, 32'hE000_0000);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("p2_req_held", {31'b0, imem_req}, 32'd1);
      chk("p2_addr_held", imem_addr, 32'h0);
      chk("p2_no_valid", {31'b0, fetch_valid}, 32'd0);
      adv();
    end
    imem_ready = 1'b1;
    adv(); adv();
    settle(); chk("p2_c5_valid", {31'b0, fetch_valid}, 32'd1);
    adv();

    // Phase 3: freeze in S_HOLD on PC=8.
    special_en = 1'b1;
    do_reset();
    push(32'd4, 32'hE000_0000);
    push(32'd8, 32'hE3A0_1005);
    cycles(4);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("p3_frz_pc", PC, 32'd8);
      chk("p3_frz_instr", instruction, 32'hE3A0_1005);
      chk("p3_frz_req", {31'b0, imem_req}, 32'd0);
      chk("p3_frz_valid", {31'b0, fetch_valid}, 32'd1);
      adv();
    end
    freeze = 1'b0;
    settle();
    chk("p3_rel_req", {31'b0, imem_req}, 32'd1);
    chk("p3_rel_addr", imem_addr, 32'd8);
    adv();
    special_en = 1'b0;

    // Phase 4: branch while waiting, stale response arrives later.
    lat = 2;
    do_reset();
    push(32'h44, 32'hE000_0040);
    adv();
    branch_taken = 1'b1;
    branch_addr = 32'h40;
    settle(); chk("p4_br_req", {31'b0, imem_req}, 32'd0);
    adv();
    branch_taken = 1'b0;
    settle(); chk("p4_disc_valid", {31'b0, fetch_valid}, 32'd0);
    adv();
    settle();
    chk("p4_redir_req", {31'b0, imem_req}, 32'd1);
    chk("p4_redir_addr", imem_addr, 32'h40);
    cycles(3);
    settle(); chk("p4_c6_valid", {31'b0, fetch_valid}, 32'd1);
    adv();

    // Phase 5: branch and freeze together in S_HOLD.
    lat = 1;
    do_reset();
    push(32'h104, 32'hE000_0100);
    cycles(2);
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    settle();
    chk("p5_vis_pc", PC, 32'd4);
    chk("p5_br_req", {31'b0, imem_req}, 32'd0);
    adv();
    freeze = 1'b0;
    branch_taken = 1'b0;
    settle();
    chk("p5_flush_valid", {31'b0, fetch_valid}, 32'd0);
    chk("p5_redir_addr", imem_addr, 32'h100);
    chk("p5_redir_req", {31'b0, imem_req}, 32'd1);
    cycles(3);

    // Phase 6: reset asserted in S_WAIT.
    lat = 3;
    do_reset();
    push(32'd4, 32'hE000_0000);
    adv();
    rst = 1'b1;
    settle(); chk("p6_rst_req", {31'b0, imem_req}, 32'd0);
    adv();
    rst = 1'b0;
    settle();
    chk("p6_req", {31'b0, imem_req}, 32'd1);
    chk("p6_addr", imem_addr, 32'h0);
    chk("p6_valid", {31'b0, fetch_valid}, 32'd0);
    chk("p6_instr", instruction, 32'h0);
    cycles(5);

    // Phase 7: redirect to top of address space; PC wraps to 0.
    lat = 1;
    do_reset();
    push(32'h0, 32'h1FFF_FFFC);
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    settle(); chk("p7_br_req", {31'b0, imem_req}, 32'd0);
    adv();
    branch_taken = 1'b0;
    settle(); chk("p7_addr", imem_addr, 32'hFFFF_FFFC);
    cycles(2);
    settle(); chk("p7_wrap_addr", imem_addr, 32'h0);
    adv();

    rst = 1'b1;
    cycles(2);
    chk("drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
